fp_mul_normalize: RTL and testbench
===================================

FP_MUL_NORMALIZE -- requirements
Module: fp_mul_normalize

Interface
REQ-001 SHALL have parameter BIAS, default 127, meaning the IEEE-754 single-precision exponent bias used for range checks.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream product valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a product this cycle.
REQ-006 SHALL have port product  input  48  unsigned 24x24 mantissa product from the 24-bit multiplier (1.x * 1.x, range [1,4)).
REQ-007 SHALL have port exp_sum  input  10  two's-complement biased exponent sum (ea + eb - BIAS).
REQ-008 SHALL have port sign_in  input  1  result sign (sa XOR sb).
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port result  output  32  packed single-precision result {sign, exp[7:0], frac[22:0]}.
REQ-012 SHALL have ports overflow, underflow  output  1 each  flags qualified by out_valid.

Function
REQ-013 SHALL be a 2-stage pipeline: stage 1 normalizes, stage 2 rounds and packs; latency 2 cycles from accept to out_valid with out_ready held high.
REQ-014 SHALL accept a transfer when in_valid & in_ready, and deliver one when out_valid & out_ready.
REQ-015 Stage 2 SHALL load when it is empty or out_ready=1; stage 1 SHALL load when it is empty or stage 2 loads; in_ready = !s1_valid | stage-2-load.
REQ-016 While out_valid=1 and out_ready=0, result/overflow/underflow SHALL hold stable; order SHALL be preserved and no transfer dropped or duplicated.
REQ-017 Normalize: if product[47]=1, frac=product[46:24], guard=product[23], sticky=|product[22:0], exp=exp_sum+1; else frac=product[45:23], guard=product[22], sticky=|product[21:0], exp=exp_sum.
REQ-018 Exponent arithmetic SHALL be 11-bit signed to avoid wrap-around.
REQ-019 Rounding per REQ-029/030; if rounding carries out of frac (all ones + 1), frac SHALL become 0 and exp SHALL increment by 1.
REQ-020 If final exp >= 255: result={sign,8'hFF,23'h0}, overflow=1.
REQ-021 If final exp <= 0: result={sign,31'h0}, underflow=1 (no subnormals).
REQ-022 If product==0: result={sign,31'h0}, both flags 0, regardless of exp_sum.
REQ-023 Otherwise result={sign,exp[7:0],frac}, both flags 0.
REQ-024 Simultaneous accept and deliver in the same cycle SHALL be supported at full throughput (one result per cycle).

Reset
REQ-025 On rstn=0, both stage valid bits SHALL clear immediately (asynchronous), independent of clk.
REQ-026 Reset values: out_valid=0, result=32'h0, overflow=0, underflow=0; in_ready=1 once rstn=1.
REQ-027 In-flight data at reset SHALL be discarded; no result from before reset SHALL ever appear after.
REQ-028 Deassertion SHALL take effect at the next rising clk; first accept possible on that edge.

Configuration
REQ-029 With macro FP_ROUND_NEAREST_EVEN_EN defined: round up when guard & (sticky | frac[0]) (round-to-nearest, ties-to-even).
REQ-030 Without FP_ROUND_NEAREST_EVEN_EN: truncate (guard/sticky ignored, never round up); latency and interface unchanged.

Verification
REQ-031 product=48'h900000000000, exp_sum=127, sign=0 -> result=32'h40100000 (2.25), flags 0, 2 cycles later.
REQ-032 product=48'h7FFFFFC00000, exp_sum=127, sign=0 -> with macro 32'h40000000 (carry-out, exp+1); without macro 32'h3FFFFFFF.
REQ-033 product=48'h800000000000, exp_sum=254, sign=1 -> result=32'hFF800000, overflow=1; exp_sum=0, product=48'h400000000000, sign=1 -> 32'h80000000, underflow=1.
REQ-034 Send 4 back-to-back products with out_ready=0 for 3 cycles -> in_ready low after 2 accepted, result stable while stalled, all 4 delivered in order once out_ready=1.
REQ-035 Assert rstn=0 mid-clock with both stages full -> out_valid=0 immediately, no stale result after release; next input yields correct result at latency 2.

Source files
------------

// File: rtl/fp_mul_normalize.sv
// Normalize, round and pack stage for a single-precision multiplier: 2-deep valid/ready pipeline.
// Optional macro FP_ROUND_NEAREST_EVEN_EN selects round-to-nearest-even; default truncates.
module fp_mul_normalize #(
  parameter int BIAS = 127
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] product,
  input  logic [9:0]  exp_sum,
  input  logic        sign_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  // Largest biased exponent (all ones) marks infinity.
  localparam logic signed [10:0] ExpMax = 11'(2 * BIAS + 1);

  logic               s1_valid_q;
  logic               s1_sign_q;
  logic               s1_zero_q;
  logic               s1_guard_q;
  logic               s1_sticky_q;
  logic [22:0]        s1_frac_q;
  logic signed [10:0] s1_exp_q;

  logic               s1_load;
  logic               s2_load;

  logic               hi;
  logic [22:0]        n_frac;
  logic               n_guard;
  logic               n_sticky;
  logic signed [10:0] n_exp;

  logic               round_up;
  logic [23:0]        rounded;
  logic signed [10:0] f_exp;
  logic [31:0]        result_d;
  logic               overflow_d;
  logic               underflow_d;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Product of two 1.x mantissas lies in [1,4); bit 47 set means it is >= 2.
  assign hi = product[47];

  always_comb begin
    n_frac   = hi ? product[46:24] : product[45:23];
    n_guard  = hi ? product[23] : product[22];
    n_sticky = hi ? (|product[22:0]) : (|product[21:0]);
    n_exp    = {exp_sum[9], exp_sum} + {10'd0, hi};
  end

`ifdef FP_ROUND_NEAREST_EVEN_EN
  assign round_up = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
`else
  logic unused_round;
  assign round_up     = 1'b0;
  assign unused_round = s1_guard_q ^ s1_sticky_q;
`endif

  always_comb begin
    rounded     = {1'b0, s1_frac_q} + 24'(round_up);
    // A carry out of the fraction leaves rounded[22:0] all zero, so only the exponent moves.
    f_exp       = s1_exp_q + {10'd0, rounded[23]};
    result_d    = {s1_sign_q, f_exp[7:0], rounded[22:0]};
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (s1_zero_q) begin
      result_d = {s1_sign_q, 31'h0};
    end else if (f_exp >= ExpMax) begin
      result_d   = {s1_sign_q, 8'hFF, 23'h0};
      overflow_d = 1'b1;
    end else if (f_exp <= 11'sd0) begin
      result_d    = {s1_sign_q, 31'h0};
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_frac_q   <= '0;
      s1_exp_q    <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q   <= sign_in;
        s1_zero_q   <= (product == 48'h0);
        s1_guard_q  <= n_guard;
        s1_sticky_q <= n_sticky;
        s1_frac_q   <= n_frac;
        s1_exp_q    <= n_exp;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      result    <= 32'h0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        result    <= result_d;
        overflow  <= overflow_d;
        underflow <= underflow_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Scoreboard bench for fp_mul_normalize: random and directed products checked against an
// arithmetic reference model; honours FP_ROUND_NEAREST_EVEN_EN like the design.
`timescale 1ns/1ps
module tb_fp_mul_normalize;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] product;
  logic [9:0]  exp_sum;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  always #5 clk = ~clk;

  fp_mul_normalize #(.BIAS(127)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .exp_sum   (exp_sum),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: scale the product into [1,2) by plain division, then round on the remainder.
  function automatic exp_t model(input logic [47:0] p, input logic [9:0] es, input logic s);
    exp_t            r;
    longint unsigned pv, shift, mant, rem, half;
    int              e;
    logic [22:0]     f;
    pv = p;
    r.res = {s, 31'h0};
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (pv == 0) return r;
    shift = (pv >= 64'h8000_0000_0000) ? 24 : 23;
    e     = $signed(es);
    if (shift == 24) e = e + 1;
    mant  = pv >> shift;
    rem   = pv - (mant << shift);
    half  = 64'd1 << (shift - 1);
`ifdef FP_ROUND_NEAREST_EVEN_EN
    if (rem > half || (rem == half && (mant % 2) == 1)) mant = mant + 1;
`endif
    if (mant >= (64'd1 << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    f = mant[22:0];
    if (e >= 255) begin
      r.res = {s, 8'hFF, 23'h0};
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.unf = 1'b1;
    end else begin
      r.res = {s, e[7:0], f};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rstn === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1)
      sbq.push_back(model(product, exp_sum, sign_in));
  end

  always @(negedge clk) begin
    if (rstn === 1'b1 && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h, required no output", result);
      end else begin
        check("sb_result", result, sbq[0].res);
        check("sb_flags", {30'd0, overflow, underflow}, {30'd0, sbq[0].ovf, sbq[0].unf});
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic drive(input logic [47:0] p, input logic [9:0] e, input logic s);
    bit ok;
    ok       = 1'b0;
    product  = p;
    exp_sum  = e;
    sign_in  = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0, required 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string name, input logic [47:0] p, input logic [9:0] e,
                        input logic s, input logic [31:0] req, input logic [1:0] flags);
    drive(p, e, s);
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check({name, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_result"}, result, req);
    check({name, "_flags"}, {30'd0, overflow, underflow}, {30'd0, flags});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec(output logic [47:0] p, output logic [9:0] e, output logic s);
    logic [23:0] a, b;
    int          k, ei;
    a = {1'b1, 23'($urandom)};
    b = {1'b1, 23'($urandom)};
    k = $urandom_range(0, 9);
    if (k == 0)      p = '0;
    else if (k == 1) p = ({24'd0, a} << 23) | (48'd1 << 22);
    else if (k == 2) p = ({24'd0, a} << 24) | (48'd1 << 23);
    else             p = {24'd0, a} * {24'd0, b};
    k = $urandom_range(0, 3);
    if (k == 0)      ei = int'($urandom_range(0, 6)) + 250;
    else if (k == 1) ei = 3 - int'($urandom_range(0, 6));
    else             ei = int'($urandom_range(0, 400)) - 100;
    e = 10'(ei);
    s = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [47:0] rp;
    logic [9:0]  re;
    logic        rs;
    logic [31:0] held;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    product   = '0;
    exp_sum   = '0;
    sign_in   = 1'b0;
    #12;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_flags", {30'd0, overflow, underflow}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    single("mul_2p25", 48'h900000000000, 10'd127, 1'b0, 32'h40100000, 2'b00);
`ifdef FP_ROUND_NEAREST_EVEN_EN
    single("round_carry", 48'h7FFFFFC00000, 10'd127, 1'b0, 32'h40000000, 2'b00);
`else
    single("round_carry", 48'h7FFFFFC00000, 10'd127, 1'b0, 32'h3FFFFFFF, 2'b00);
`endif
    single("overflow", 48'h800000000000, 10'd254, 1'b1, 32'hFF800000, 2'b10);
    single("underflow", 48'h400000000000, 10'd0, 1'b1, 32'h80000000, 2'b01);
    single("zero_product", 48'h0, 10'd300, 1'b1, 32'h80000000, 2'b00);

    // Back-to-back with a stalled sink: two accepted, then backpressure.
    out_ready = 1'b0;
    drive(48'h500000000000, 10'd130, 1'b0);
    drive(48'hA00000000000, 10'd100, 1'b1);
    product  = 48'h6000000A0000;
    exp_sum  = 10'd5;
    sign_in  = 1'b0;
    held     = result;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_hold", result, held);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(48'h6000000A0000, 10'd5, 1'b0);
    drive(48'hFFFFFF000001, 10'd200, 1'b1);
    in_valid = 1'b0;
    drain();

    for (int c = 0; c < 400; c++) begin
      rand_vec(rp, re, rs);
      product   = rp;
      exp_sum   = re;
      sign_in   = rs;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset mid-cycle with both stages full.
    out_ready = 1'b0;
    drive(48'h900000000000, 10'd127, 1'b0);
    drive(48'h900000000000, 10'd128, 1'b1);
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_result", result, 32'h0);
    sbq.delete();
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("no_stale_after_reset", {31'd0, out_valid}, 32'd0);
    end
    single("post_reset", 48'h900000000000, 10'd127, 1'b0, 32'h40100000, 2'b00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
